uart_pixel_rx: RTL

Upstream pixel source for the ST7789 LCD SPI streamer. Receives a raw RGB565 byte stream on `ser_rx` (8N1 UART, big-endian pixels), assembles 16-bit pixels, and buffers them in a small FIFO. Pixels go out on a valid/ready stream with a start-of-frame marker; the LCD stage consumes that stream in place of its internal colour generator. A line-idle timeout realigns byte phase and frame position so the host can resynchronise without an in-band sync code.

---
 rtl/uart_pixel_rx.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_pixel_rx.sv
// uart_pixel_rx: UART receiver that assembles big-endian RGB565 pixels from
// a raw byte stream, tags pixel 0 of each frame, and buffers pixels in a
// small FIFO driving a valid/ready stream. A line-idle gap realigns byte
// phase and frame position so the host can resynchronise.
// Optional feature: define RX_PARITY_EN for 8E1 framing with parity_err.

module uart_pixel_rx #(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 32400,
  parameter int IDLE_BITS    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        clr_err,
  output logic        overflow,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int CPB        = CLK_HZ / BAUD;
  localparam int CNT_W      = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDLE_LIMIT = IDLE_BITS * CPB;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int FW         = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_fall, w_tick, w_stop_tick;
  logic             w_load_half, w_load_bit, w_shift_en;
  logic             w_byte_valid, w_stop_bad, w_par_bad;

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_idle_fire;

  logic          r_phase;
  logic [7:0]    r_pix_hi;
  logic          r_push;
  logic [15:0]   r_push_pix;
  logic [FW-1:0] r_frame_cnt;

  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [16:0]   w_head;
  logic          w_pop, w_push_acc, w_push_drop;

  logic r_overflow, r_frame_err;

  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_tick      = (r_bit_cnt == '0);
  assign w_stop_tick = (r_state == S_STOP) && w_tick;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= ser_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // RX next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_load_half  = 1'b0;
    w_load_bit   = 1'b0;
    w_shift_en   = 1'b0;
    w_byte_valid = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_load_half  = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!r_rx_sync) begin
            w_state_next = S_DATA;
            w_load_bit   = 1'b1;
          end else begin
            w_state_next = S_IDLE;  // glitch shorter than half a bit
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_load_bit = 1'b1;
`ifdef RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_next = S_PARITY;
`else
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_load_bit   = 1'b1;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_state_next = S_IDLE;
          w_stop_bad   = ~r_rx_sync;
          w_byte_valid = r_rx_sync & ~w_par_bad;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit timer, data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_load_half)     r_bit_cnt <= CNT_W'(CPB / 2);
      else if (w_load_bit) r_bit_cnt <= CNT_W'(CPB - 1);
      else if (!w_tick)    r_bit_cnt <= r_bit_cnt - CNT_W'(1);
      if (r_state == S_IDLE) r_bit_idx <= '0;
      else if (w_shift_en)   r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_bad, r_parity_err;
  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;

  // Even-parity check captured in PARITY, reported at the stop sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_tick) r_par_bad <= (^r_shift) ^ r_rx_sync;
      if (w_stop_tick && r_par_bad) r_parity_err <= 1'b1;
      else if (clr_err)             r_parity_err <= 1'b0;
    end
  end
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Idle gap detector: counts line-high cycles in IDLE, fires once per gap.
  assign w_idle_fire = (r_state == S_IDLE) && r_rx_sync &&
                       (r_idle_cnt == IDLE_W'(IDLE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) r_idle_cnt <= '0;
    else if (r_state != S_IDLE || !r_rx_sync) r_idle_cnt <= '0;
    else if (r_idle_cnt != IDLE_W'(IDLE_LIMIT)) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
  end

  // Byte pairing into pixels; the push is registered one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_phase    <= 1'b0;
      r_pix_hi   <= '0;
      r_push     <= 1'b0;
      r_push_pix <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_byte_valid) begin
        if (!r_phase) begin
          r_pix_hi <= r_shift;
          r_phase  <= 1'b1;
        end else begin
          r_push     <= 1'b1;
          r_push_pix <= {r_pix_hi, r_shift};
          r_phase    <= 1'b0;
        end
      end else if (w_idle_fire) begin
        r_phase <= 1'b0;  // discard any held high byte
      end
    end
  end

  assign w_pop       = (r_count != '0) && pix_ready;
  assign w_push_acc  = r_push && ((r_count != (AW+1)'(FIFO_DEPTH)) || w_pop);
  assign w_push_drop = r_push && !w_push_acc;

  // Frame position of the next accepted pixel.
  always_ff @(posedge clk) begin
    if (!resetn) r_frame_cnt <= '0;
    else if (w_idle_fire) r_frame_cnt <= '0;
    else if (w_push_acc) begin
      if (r_frame_cnt == FW'(FRAME_PIXELS - 1)) r_frame_cnt <= '0;
      else                                       r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is left unreset; occupancy gates every read, so stale
    // contents are never observable and the array can map to plain RAM.
    if (w_push_acc)
      r_mem[r_rd_ptr + r_count[AW-1:0]] <= {(r_frame_cnt == '0), r_push_pix};
  end

  // FIFO read pointer and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_acc) - (AW+1)'(w_pop);
    end
  end

  // Sticky error flags; a set on the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push_drop)  r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_stop_tick && w_stop_bad) r_frame_err <= 1'b1;
      else if (clr_err)              r_frame_err <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign pix_valid = (r_count != '0);
  assign pix_data  = pix_valid ? w_head[15:0] : 16'h0000;
  assign pix_sof   = pix_valid & w_head[16];
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule
